// File: rtl/bus_responder_pkg.sv
// Shared types and constants for the instruction/data bus responder.
//   resp_state_t     : responder FSM states
//   gnt_t            : which bus currently owns the SRAM
//   ibus_*/dbus_*    : core bus request/response payloads
package bus_responder_pkg;

  localparam int unsigned RESP_MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/bus_responder_sram_1rw.sv
// Single-port 64-bit SRAM, synchronous read, byte write enable.
//   clk     : clock
//   en_i    : port enable; be_i==0 means read, otherwise byte write
//   be_i    : byte write enables
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data (holds until the next read)
module sram_1rw #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = 12
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [7:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH_WORDS];
  logic [63:0] rdata_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (be_i == 8'h00) begin
        rdata_q <= mem_q[addr_i];
      end
      for (int b = 0; b < 8; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder: arbitrates ibus/dbus requests onto one SRAM and
// answers after a fixed latency.
//   clk, reset : clock, synchronous active-high reset
//   ireq/iresp : instruction bus request/response (32-bit read data)
//   dreq/dresp : data bus request/response (64-bit, byte strobes)
//   err        : pulses with data_ok when the served address is out of range
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 3;

  resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  gnt_t        gnt_q, gnt_d;

  logic        ok_i_q, ok_d_q, err_q, rd_ok_q, hi_q;

  gnt_t          arb, cur_gnt;
  logic          cur_valid, cur_write, in_range, resp_next, rd_en, wr_en;
  logic [63:0]   cur_addr, off, rdata, dword;
  logic [AW-1:0] widx;
  logic          unused_size;

  assign unused_size = ^dreq.size;

  // dbus wins arbitration; in IDLE the fresh grant steers decode so the
  // read can already be issued there when LATENCY==1.
  assign arb       = dreq.valid ? GNT_D : GNT_I;
  assign cur_gnt   = (state_q == IDLE) ? arb : gnt_q;
  assign cur_valid = (cur_gnt == GNT_D) ? dreq.valid : ireq.valid;
  assign cur_addr  = (cur_gnt == GNT_D) ? dreq.addr : ireq.addr;
  assign cur_write = (cur_gnt == GNT_D) && (dreq.strobe != 8'h00);
  assign off       = cur_addr - BASE_ADDR;
  assign in_range  = off < SPAN;
  assign widx      = off[AW+2:3];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (ireq.valid || dreq.valid) begin
          gnt_d = arb;
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (!cur_valid) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read goes out the cycle before RESP; write commits during RESP itself.
  assign resp_next = (state_d == RESP);
  assign rd_en     = resp_next && !cur_write && in_range;
  assign wr_en     = (state_q == RESP) && (gnt_q == GNT_D) &&
                     (dreq.strobe != 8'h00) && in_range && !reset;

  sram_1rw #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk     (clk),
    .en_i    (rd_en || wr_en),
    .be_i    (wr_en ? dreq.strobe : 8'h00),
    .addr_i  (widx),
    .wdata_i (dreq.data),
    .rdata_o (rdata)
  );

  // State and response flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      gnt_q   <= GNT_I;
      ok_i_q  <= 1'b0;
      ok_d_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ok_i_q  <= resp_next && (cur_gnt == GNT_I);
      ok_d_q  <= resp_next && (cur_gnt == GNT_D);
      err_q   <= resp_next && !in_range;
      rd_ok_q <= resp_next && in_range && !cur_write;
      hi_q    <= cur_addr[2];
    end
  end

  // Response data is the SRAM output register, zeroed outside a valid read.
  assign dword = rd_ok_q ? rdata : 64'h0;

  always_comb begin
    iresp.addr_ok = ok_i_q;
    iresp.data_ok = ok_i_q;
    iresp.data    = ok_i_q ? (hi_q ? dword[63:32] : dword[31:0]) : 32'h0;
    dresp.addr_ok = ok_d_q;
    dresp.data_ok = ok_d_q;
    dresp.data    = ok_d_q ? dword : 64'h0;
  end

  assign err = err_q;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder against a word-array memory model.
module tb_bus_responder;
  import bus_responder_pkg::*;

  localparam int unsigned DEPTH = 4096;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

  logic       clk, reset, err;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mdl [int unsigned];

  bus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
    .dreq(dreq), .dresp(dresp), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic in_rng(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < SPAN);
  endfunction

  function automatic int unsigned widx(input logic [63:0] a);
    return int'((a - BASE) / 64'd8);
  endfunction

  function automatic logic [63:0] m_read(input logic [63:0] a);
    if (!in_rng(a) || !mdl.exists(widx(a))) return 64'h0;
    return mdl[widx(a)];
  endfunction

  task automatic m_write(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    logic [63:0] w;
    if (!in_rng(a)) return;
    w = m_read(a);
    for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mdl[widx(a)] = w;
  endtask

  function automatic logic [31:0] m_half(input logic [63:0] a);
    logic [63:0] w;
    w = m_read(a);
    return a[2] ? w[63:32] : w[31:0];
  endfunction

  // One dbus transaction started at a negedge; returns observations only.
  task automatic d_txn(input logic [63:0] a, input logic [7:0] s, input logic [63:0] wd,
                       output logic [63:0] rd, output logic e, output int lat, output logic pok);
    pok = 1'b1; lat = -1; rd = 64'h0; e = 1'b0;
    dreq = '{valid: 1'b1, addr: a, size: 3'd3, strobe: s, data: wd};
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (iresp !== '0) pok = 1'b0;
      if (dresp.addr_ok !== dresp.data_ok) pok = 1'b0;
      if (dresp.data_ok === 1'b1) begin
        lat = k; rd = dresp.data; e = err;
        break;
      end
      if (err !== 1'b0) pok = 1'b0;
    end
    dreq.valid = 1'b0;
    @(negedge clk);
    if (dresp !== '0 || err !== 1'b0) pok = 1'b0;
  endtask

  task automatic i_txn(input logic [63:0] a, output logic [31:0] rd, output logic e,
                       output int lat, output logic pok);
    pok = 1'b1; lat = -1; rd = 32'h0; e = 1'b0;
    ireq = '{valid: 1'b1, addr: a};
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dresp !== '0) pok = 1'b0;
      if (iresp.addr_ok !== iresp.data_ok) pok = 1'b0;
      if (iresp.data_ok === 1'b1) begin
        lat = k; rd = iresp.data; e = err;
        break;
      end
      if (err !== 1'b0) pok = 1'b0;
    end
    ireq.valid = 1'b0;
    @(negedge clk);
    if (iresp !== '0 || err !== 1'b0) pok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (iresp !== '0) begin n_bad++; $display("FAIL reset_iresp got=%h want=0", iresp); end
    n_cmp++; if (dresp !== '0) begin n_bad++; $display("FAIL reset_dresp got=%h want=0", dresp); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_iread();
    logic [63:0] rd; logic [31:0] ir; logic e, pok; int lat;
    d_txn(BASE, 8'hFF, 64'h1122_3344_5566_7788, rd, e, lat, pok);
    m_write(BASE, 8'hFF, 64'h1122_3344_5566_7788);
    n_cmp++; if (lat !== LAT || e !== 1'b0 || rd !== 64'h0 || pok !== 1'b1) begin
      n_bad++; $display("FAIL preload_write lat=%0d err=%b data=%h proto=%b want lat=%0d err=0 data=0 proto=1", lat, e, rd, pok, LAT);
    end
    i_txn(BASE + 64'd4, ir, e, lat, pok);
    n_cmp++; if (ir !== 32'h1122_3344) begin n_bad++; $display("FAIL iread_hi data got=%h want=11223344", ir); end
    n_cmp++; if (lat !== LAT || e !== 1'b0 || pok !== 1'b1) begin
      n_bad++; $display("FAIL iread_hi_timing lat=%0d err=%b proto=%b want lat=%0d err=0 proto=1", lat, e, pok, LAT);
    end
    i_txn(BASE, ir, e, lat, pok);
    n_cmp++; if (ir !== 32'h5566_7788) begin n_bad++; $display("FAIL iread_lo data got=%h want=55667788", ir); end
  endtask

  task automatic test_strobe_write();
    logic [63:0] rd; logic e, pok; int lat;
    d_txn(BASE + 64'd8, 8'hFF, 64'h0, rd, e, lat, pok);
    m_write(BASE + 64'd8, 8'hFF, 64'h0);
    d_txn(BASE + 64'd8, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB, rd, e, lat, pok);
    m_write(BASE + 64'd8, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB);
    n_cmp++; if (rd !== 64'h0 || e !== 1'b0 || pok !== 1'b1) begin
      n_bad++; $display("FAIL strobe_write_resp data=%h err=%b proto=%b want data=0 err=0 proto=1", rd, e, pok);
    end
    d_txn(BASE + 64'd8, 8'h00, 64'h0, rd, e, lat, pok);
    n_cmp++; if (rd !== 64'h0000_0000_AAAA_BBBB) begin
      n_bad++; $display("FAIL strobe_readback got=%h want=00000000aaaabbbb", rd);
    end
  endtask

  task automatic test_both_valid();
    int dk = -1, ik = -1; logic overlap = 1'b0;
    logic [63:0] drd = 64'h0; logic [31:0] ird = 32'h0;
    dreq = '{valid: 1'b1, addr: BASE + 64'd8, size: 3'd3, strobe: 8'h00, data: 64'h0};
    ireq = '{valid: 1'b1, addr: BASE + 64'd4};
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (dresp.data_ok === 1'b1 && iresp.data_ok === 1'b1) overlap = 1'b1;
      if (dresp.data_ok === 1'b1) begin dk = k; drd = dresp.data; dreq.valid = 1'b0; end
      if (iresp.data_ok === 1'b1) begin ik = k; ird = iresp.data; ireq.valid = 1'b0; break; end
    end
    ireq.valid = 1'b0; dreq.valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (dk !== LAT) begin n_bad++; $display("FAIL both_dbus_latency got=%0d want=%0d", dk, LAT); end
    n_cmp++; if (ik !== 2*LAT + 1) begin n_bad++; $display("FAIL both_ibus_latency got=%0d want=%0d", ik, 2*LAT+1); end
    n_cmp++; if (overlap !== 1'b0) begin n_bad++; $display("FAIL both_overlap got=%b want=0", overlap); end
    n_cmp++; if (drd !== m_read(BASE + 64'd8) || ird !== m_half(BASE + 64'd4)) begin
      n_bad++; $display("FAIL both_data d=%h i=%h want d=%h i=%h", drd, ird, m_read(BASE + 64'd8), m_half(BASE + 64'd4));
    end
  endtask

  task automatic test_out_of_range();
    logic [63:0] rd, top; logic [31:0] ir; logic e, pok; int lat;
    top = BASE + SPAN - 64'd8;
    d_txn(top, 8'hFF, 64'h5A5A_0123_4567_89AB, rd, e, lat, pok);
    m_write(top, 8'hFF, 64'h5A5A_0123_4567_89AB);
    d_txn(64'h7FFF_FFF8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, rd, e, lat, pok);
    n_cmp++; if (e !== 1'b1 || lat !== LAT || pok !== 1'b1) begin
      n_bad++; $display("FAIL oor_write err=%b lat=%0d proto=%b want err=1 lat=%0d proto=1", e, lat, pok, LAT);
    end
    d_txn(top, 8'h00, 64'h0, rd, e, lat, pok);
    n_cmp++; if (rd !== m_read(top) || e !== 1'b0) begin
      n_bad++; $display("FAIL oor_write_dropped got=%h err=%b want=%h err=0", rd, e, m_read(top));
    end
    d_txn(BASE + SPAN, 8'h00, 64'h0, rd, e, lat, pok);
    n_cmp++; if (rd !== 64'h0 || e !== 1'b1) begin
      n_bad++; $display("FAIL oor_dread got=%h err=%b want=0 err=1", rd, e);
    end
    i_txn(BASE + SPAN + 64'd4, ir, e, lat, pok);
    n_cmp++; if (ir !== 32'h0 || e !== 1'b1 || pok !== 1'b1) begin
      n_bad++; $display("FAIL oor_iread got=%h err=%b proto=%b want=0 err=1 proto=1", ir, e, pok);
    end
  endtask

  task automatic test_abort();
    logic [63:0] rd; logic e, pok; int lat; logic seen = 1'b0;
    dreq = '{valid: 1'b1, addr: BASE, size: 3'd3, strobe: 8'hFF, data: 64'hCAFE_F00D_CAFE_F00D};
    @(negedge clk);
    dreq.valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (dresp.data_ok !== 1'b0 || err !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_resp got=%b want=0", seen); end
    d_txn(BASE, 8'h00, 64'h0, rd, e, lat, pok);
    n_cmp++; if (rd !== m_read(BASE) || lat !== LAT) begin
      n_bad++; $display("FAIL abort_old_data got=%h lat=%0d want=%h lat=%0d", rd, lat, m_read(BASE), LAT);
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat = -1; logic [63:0] rd = 64'h0; logic seen = 1'b0;
    dreq = '{valid: 1'b1, addr: BASE, size: 3'd3, strobe: 8'hFF, data: 64'h0BAD_0BAD_0BAD_0BAD};
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (iresp !== '0 || dresp !== '0 || err !== 1'b0) begin
      n_bad++; $display("FAIL midwait_reset_out i=%h d=%h err=%b want all 0", iresp, dresp, err);
    end
    dreq = '{valid: 1'b1, addr: BASE, size: 3'd3, strobe: 8'h00, data: 64'h0};
    @(negedge clk);
    if (dresp.data_ok !== 1'b0) seen = 1'b1;
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dresp.data_ok === 1'b1) begin lat = k; rd = dresp.data; break; end
    end
    dreq.valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL req_during_reset got=%b want=0", seen); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL post_reset_latency got=%0d want=%0d", lat, LAT); end
    n_cmp++; if (rd !== m_read(BASE)) begin n_bad++; $display("FAIL reset_discard_write got=%h want=%h", rd, m_read(BASE)); end
  endtask

  task automatic test_random();
    logic [63:0] a, wd, rd; logic [31:0] ir; logic [7:0] s; logic e, pok; int lat;
    for (int w = 0; w < 8; w++) begin
      wd = {$urandom, $urandom};
      d_txn(BASE + 64'(w) * 64'd8, 8'hFF, wd, rd, e, lat, pok);
      m_write(BASE + 64'(w) * 64'd8, 8'hFF, wd);
    end
    for (int n = 0; n < 60; n++) begin
      a = BASE + 64'($urandom_range(0, 7)) * 64'd8;
      if ($urandom_range(0, 9) == 0) a = a + SPAN;
      if ($urandom_range(0, 2) == 0) begin
        a = a + 64'($urandom_range(0, 1)) * 64'd4;
        i_txn(a, ir, e, lat, pok);
        n_cmp++; if (ir !== m_half(a) || e !== !in_rng(a) || lat !== LAT || pok !== 1'b1) begin
          n_bad++; $display("FAIL rand_i[%0d] a=%h data=%h err=%b lat=%0d proto=%b want data=%h err=%b lat=%0d",
                            n, a, ir, e, lat, pok, m_half(a), !in_rng(a), LAT);
        end
      end else begin
        s  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
        wd = {$urandom, $urandom};
        d_txn(a, s, wd, rd, e, lat, pok);
        n_cmp++; if (rd !== ((s == 8'h00) ? m_read(a) : 64'h0) || e !== !in_rng(a) || lat !== LAT || pok !== 1'b1) begin
          n_bad++; $display("FAIL rand_d[%0d] a=%h s=%h data=%h err=%b lat=%0d proto=%b want data=%h err=%b lat=%0d",
                            n, a, s, rd, e, lat, pok, (s == 8'h00) ? m_read(a) : 64'h0, !in_rng(a), LAT);
        end
        m_write(a, s, wd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_iread();
    test_strobe_write();
    test_both_valid();
    test_out_of_range();
    test_abort();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
